// File: rtl/seg_pkg.sv
// seg_pkg: shared widths, mode and step encodings for seg_value_counter
package seg_pkg;
    localparam int LSEG_W = 4;
    localparam int RSEG_W = 3;
    typedef enum logic {MANUAL, AUTO} mode_t;
    typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_CLR} step_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability debouncer and press pulse for one raw button
//  clk    in  system clock
//  reset  in  asynchronous reset, active-high
//  btn    in  raw asynchronous button level
//  press  out one-cycle pulse on the debounced rising edge
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
    logic s1, s2, lvl, lvl_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            lvl_q <= lvl;
            // cnt holds the number of consecutive differing samples seen so far
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign press = lvl & ~lvl_q;
endmodule

// File: rtl/seg_value_counter.sv
// seg_value_counter: debounced buttons driving a two-digit (lseg:rseg) up/down counter
//  clk      in  system clock
//  reset    in  asynchronous reset, active-high
//  btn_inc  in  raw increment button
//  btn_dec  in  raw decrement button
//  btn_clr  in  raw clear button
//  auto_en  in  auto-run request (only when AUTO_RUN_EN is defined)
//  lseg     out high digit, 0..LSEG_MAX
//  rseg     out low digit, 0..RSEG_MAX
//  wrap     out one-cycle pulse when the count wraps in either direction
// Optional feature macro: AUTO_RUN_EN (auto_en port, MANUAL/AUTO FSM and prescaler).
module seg_value_counter
    import seg_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int LSEG_MAX   = 15,
    parameter int RSEG_MAX   = 7,
    parameter int AUTO_DIV   = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              btn_clr,
`ifdef AUTO_RUN_EN
    input  logic              auto_en,
`endif
    output logic [LSEG_W-1:0] lseg,
    output logic [RSEG_W-1:0] rseg,
    output logic              wrap
);
    logic inc_p, dec_p, clr_p;
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (.clk(clk), .reset(reset), .btn(btn_inc), .press(inc_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec (.clk(clk), .reset(reset), .btn(btn_dec), .press(dec_p));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (.clk(clk), .reset(reset), .btn(btn_clr), .press(clr_p));
    step_t man_step, step;
    assign man_step = clr_p ? STEP_CLR : (inc_p ^ dec_p) ? (inc_p ? STEP_INC : STEP_DEC) : STEP_NONE;
`ifdef AUTO_RUN_EN
    localparam int PW = $clog2(AUTO_DIV);
    mode_t mode, mode_nxt;
    logic a1, a2, tc;
    logic [PW-1:0] pre;
    assign tc = (mode == AUTO) && (pre == PW'(AUTO_DIV - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a1   <= 1'b0;
            a2   <= 1'b0;
            mode <= MANUAL;
            pre  <= '0;
        end else begin
            a1   <= auto_en;
            a2   <= a1;
            mode <= mode_nxt;
            // held at 0 in MANUAL, so entering AUTO always starts a full period
            pre  <= (mode == MANUAL || clr_p || tc) ? '0 : pre + 1'b1;
        end
    end
    always_comb begin
        mode_nxt = mode;
        step     = man_step;
        case (mode)
            MANUAL: mode_nxt = a2 ? AUTO : MANUAL;
            AUTO: begin
                mode_nxt = a2 ? AUTO : MANUAL;
                step     = clr_p ? STEP_CLR : tc ? STEP_INC : STEP_NONE;
            end
            default: mode_nxt = MANUAL;
        endcase
    end
`else
    assign step = man_step;
`endif
    logic [4:0] l5, r5;
    logic [LSEG_W-1:0] l_nxt;
    logic [RSEG_W-1:0] r_nxt;
    logic w_nxt, lmax, rmax, lz, rz;
    always_comb begin
        l5    = {1'b0, lseg};
        r5    = {2'b0, rseg};
        lmax  = l5 == 5'(LSEG_MAX);
        rmax  = r5 == 5'(RSEG_MAX);
        lz    = l5 == 5'd0;
        rz    = r5 == 5'd0;
        l_nxt = lseg;
        r_nxt = rseg;
        w_nxt = 1'b0;
        case (step)
            STEP_CLR: begin
                l_nxt = '0;
                r_nxt = '0;
            end
            STEP_INC: begin
                r_nxt = rmax ? '0 : RSEG_W'(r5 + 5'd1);
                l_nxt = !rmax ? lseg : lmax ? '0 : LSEG_W'(l5 + 5'd1);
                w_nxt = rmax && lmax;
            end
            STEP_DEC: begin
                r_nxt = rz ? RSEG_W'(RSEG_MAX) : RSEG_W'(r5 - 5'd1);
                l_nxt = !rz ? lseg : lz ? LSEG_W'(LSEG_MAX) : LSEG_W'(l5 - 5'd1);
                w_nxt = rz && lz;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lseg <= '0;
            rseg <= '0;
            wrap <= 1'b0;
        end else begin
            lseg <= l_nxt;
            rseg <= r_nxt;
            wrap <= w_nxt;
        end
    end
endmodule

// File: tb/tb_seg_value_counter.sv
// tb_seg_value_counter: scoreboard bench for seg_value_counter (DEB_CYCLES=4, AUTO_DIV=8)
module tb_seg_value_counter;
    localparam int DEB = 4;
    localparam int LAT = DEB + 3;
    localparam logic [2:0] INC = 3'b001, DEC = 3'b010, CLR = 3'b100;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] btn = '0;
    logic [3:0] lseg;
    logic [2:0] rseg;
    logic wrap;
`ifdef AUTO_RUN_EN
    logic auto_en = 1'b0;
`endif
    seg_value_counter #(.DEB_CYCLES(DEB), .LSEG_MAX(15), .RSEG_MAX(7), .AUTO_DIV(8)) dut (
        .clk(clk),
        .reset(reset),
        .btn_inc(btn[0]),
        .btn_dec(btn[1]),
        .btn_clr(btn[2]),
`ifdef AUTO_RUN_EN
        .auto_en(auto_en),
`endif
        .lseg(lseg),
        .rseg(rseg),
        .wrap(wrap)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_chk = 0;
    int n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    endtask
    typedef struct {
        int cyc;
        logic [7:0] val;
        string tag;
    } exp_t;
    exp_t q[$];
    // reference count as one flat value 0..127 = lseg*8 + rseg
    int v = 0;
    logic w = 1'b0;
    function automatic logic [7:0] pack(int val, logic wr);
        logic [6:0] t;
        t = 7'(val);
        return {t, wr};
    endfunction
    task automatic push(input string tag, input int at);
        q.push_back('{cyc: at, val: pack(v, w), tag: tag});
    endtask
    task automatic model(input logic [2:0] m);
        w = 1'b0;
        if (m[2]) v = 0;
        else if (m[0] && !m[1]) begin
            w = v == 127;
            v = (v + 1) % 128;
        end else if (m[1] && !m[0]) begin
            w = v == 0;
            v = (v + 127) % 128;
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask
    task automatic act(input string tag, input logic [2:0] m);
        model(m);
        push(tag, cyc + LAT);
        btn = m;
        repeat (10) tick();
        btn = '0;
        repeat (12) tick();
    endtask
    logic [7:0] hold = '0;
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            check(e.tag, {lseg, rseg, wrap}, e.val);
            hold = {e.val[7:1], 1'b0};
        end else begin
            check("hold", {lseg, rseg, wrap}, hold);
        end
    end
    initial begin
        int a0;
        repeat (3) tick();
        push("reset", cyc);
        reset = 1'b0;
        repeat (2) tick();
        btn = INC;
        repeat (3) tick();
        btn = '0;
        repeat (12) tick();
        act("inc_first", INC);
        btn = INC; tick();
        btn = '0; tick();
        btn = INC; tick();
        btn = '0; tick();
        act("bounce", INC);
        for (int i = 0; i < 5; i++) act("inc_run", INC);
        act("inc_carry", INC);
        act("dec_borrow", DEC);
        act("clr", CLR);
        act("dec_wrap", DEC);
        act("inc_wrap", INC);
        act("dec_wrap2", DEC);
        act("dec_plain", DEC);
        act("inc_dec", INC | DEC);
        act("clr_all", INC | DEC | CLR);
        act("inc_a", INC);
        act("inc_b", INC);
        btn = INC;
        repeat (2) tick();
        reset = 1'b1;
        v = 0;
        w = 1'b0;
        push("async_reset", cyc);
        repeat (3) tick();
        reset = 1'b0;
        model(INC);
        push("held_thru_reset", cyc + LAT);
        repeat (10) tick();
        btn = '0;
        repeat (12) tick();
`ifdef AUTO_RUN_EN
        act("pre_auto_clr", CLR);
        a0 = cyc;
        auto_en = 1'b1;
        model(INC); push("auto1", a0 + 11);
        model(INC); push("auto2", a0 + 19);
        model(INC); push("auto3", a0 + 27);
        model(INC); push("auto4", a0 + 35);
        model(CLR); push("auto_clr", a0 + 36);
        model(INC); push("auto5", a0 + 44);
        model(INC); push("auto6", a0 + 52);
        wait_until(a0 + 12);
        btn = INC;
        wait_until(a0 + 22);
        btn = '0;
        wait_until(a0 + 29);
        btn = CLR;
        wait_until(a0 + 39);
        btn = '0;
        wait_until(a0 + 53);
        auto_en = 1'b0;
        wait_until(a0 + 75);
        act("manual_again", INC);
`endif
        repeat (5) tick();
        check("drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
